trace_fifo: RTL and testbench
=============================

// Module: trace_fifo
//
// PURPOSE
// Downstream observer of whole_cpu, sitting beside the monitor.
// - Each enabled cycle, compares A/B/X/Q against shadow copies.
// - On any change, pushes one timestamped record (pc, ir, change mask, all four values) into a FIFO.
// - A consumer drains the FIFO over a valid/ready handshake for a trace dump or serial output.
// - Dropped records are counted, never silently lost.
//
// PARAMETERS
// WIDTH    8   data width of pc, ir and each register
// DEPTH    16  FIFO entries; power of two, >= 2
// STAMP_W  16  cycle-stamp width
//
// PORTS
// clk          in   1        system clock, rising edge
// reset        in   1        synchronous, active-high
// enable       in   1        capture enable; 0 freezes stamp, shadows and pushes
// pc           in   WIDTH    CPU program counter
// ir           in   WIDTH    CPU instruction register
// a, b, x, q   in   WIDTH    CPU register contents
// out_valid    out  1        head record available
// out_ready    in   1        consumer accepts head record
// out_stamp    out  STAMP_W  cycle stamp of head record
// out_pc       out  WIDTH    pc of head record
// out_ir       out  WIDTH    ir of head record
// out_mask     out  4        changed registers; bit 0=A, 1=B, 2=X, 3=Q
// out_a        out  WIDTH    A value of head record
// out_b        out  WIDTH    B value of head record
// out_x        out  WIDTH    X value of head record
// out_q        out  WIDTH    Q value of head record
// count        out  log2(DEPTH)+1  entries currently held
// overflow     out  8        dropped-record counter, saturates at 255
//
// BEHAVIOUR
// Reset
// - All outputs 0; FIFO empty; stamp=0; shadows=0; primed=0.
// - Reset mid-operation flushes everything; any pop that cycle is ignored.
//
// Stamp
// - Increments by 1 per enabled cycle; wraps 2^STAMP_W-1 -> 0.
// - A record carries the stamp value before that cycle's increment.
//
// Priming
// - First enabled cycle after reset loads shadows from a/b/x/q; primed:=1; no push.
//
// Change detection
// - Applies when primed && enable.
// - mask = {q!=sq, x!=sx, b!=sb, a!=sa}.
// - mask!=0 requests a push; shadows always reload.
//
// Handshake
// - pop = out_valid && out_ready.
// - Head outputs are show-ahead and stable while out_valid && !out_ready.
// - Push into empty FIFO: out_valid=1 on the next cycle (1-cycle latency).
//
// Full
// - Push with full && !pop: record dropped; overflow += 1, saturating at 255.
// - Push with full && pop: both happen; count unchanged.
//
// Other cycles
// - Push and pop in the same cycle at 0<count<DEPTH: count unchanged.
// - enable=0: no push, no stamp or shadow change; pops still serviced.
// - Pointers are log2(DEPTH) bits and wrap naturally; count distinguishes full from empty.
//
// TESTING
// 1. Reset, enable=1, a=0; a:=5 on 2nd enabled cycle, ready=1
//    -> one record: mask=0001, out_a=5, stamp=1.
// 2. a and q change in the same cycle
//    -> single record, mask=1001, out_b/out_x unchanged values.
// 3. ready=0, 20 consecutive changes, DEPTH=16
//    -> count=16, overflow=4; draining yields stamps in order, no gaps among the first 16.
// 4. Full FIFO, change and ready=1 in the same cycle
//    -> count stays 16, overflow unchanged, new record at tail.
// 5. Stamp at 16'hFFFF with a change, then another change
//    -> stamps FFFF then 0000.
// 6. reset=1 while count=7 and out_ready=1
//    -> next cycle count=0, out_valid=0, overflow=0; first enabled cycle after reset emits nothing.

Source files
------------

// File: rtl/trace_fifo.sv
// Change-triggered trace recorder for whole_cpu: timestamps every A/B/X/Q update
// and queues it in a show-ahead FIFO drained over a valid/ready handshake.
module trace_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         ir,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_ir,
  output logic [3:0]               out_mask,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_x,
  output logic [WIDTH-1:0]         out_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   ir;
    logic [3:0]         mask;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   q;
  } rec_t;

  rec_t               r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [7:0]         r_overflow;
  logic [STAMP_W-1:0] r_stamp;
  logic               r_primed;
  logic [WIDTH-1:0]   r_sa, r_sb, r_sx, r_sq;

  logic [3:0] w_mask;
  logic       w_push_req;
  logic       w_valid;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  rec_t       w_new;
  rec_t       w_head;

  assign w_mask     = {q != r_sq, x != r_sx, b != r_sb, a != r_sa};
  assign w_push_req = enable && r_primed && (w_mask != 4'b0000);
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = w_valid && out_ready;
  // A pop frees the slot the full-FIFO push lands in, so both proceed together.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_new = '{stamp: r_stamp, pc: pc, ir: ir, mask: w_mask,
                   a: a, b: b, x: x, q: q};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stamp  <= '0;
      r_primed <= 1'b0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sx     <= '0;
      r_sq     <= '0;
    end else if (enable) begin
      r_stamp  <= r_stamp + STAMP_W'(1);
      r_primed <= 1'b1;
      r_sa     <= a;
      r_sb     <= b;
      r_sx     <= x;
      r_sq     <= q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_overflow != 8'hFF)) r_overflow <= r_overflow + 8'd1;
    end
  end

  // Storage is not reset; head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_new;
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = w_valid;
  assign out_stamp = w_valid ? w_head.stamp : '0;
  assign out_pc    = w_valid ? w_head.pc    : '0;
  assign out_ir    = w_valid ? w_head.ir    : '0;
  assign out_mask  = w_valid ? w_head.mask  : '0;
  assign out_a     = w_valid ? w_head.a     : '0;
  assign out_b     = w_valid ? w_head.b     : '0;
  assign out_x     = w_valid ? w_head.x     : '0;
  assign out_q     = w_valid ? w_head.q     : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_trace_fifo.sv
// Directed bench for trace_fifo: priming, change masks, overflow, full+pop,
// stamp wrap and mid-run reset, with hand-computed expectations.
module tb_trace_fifo;

  logic        clk = 1'b0;
  logic        reset, enable, out_ready;
  logic [7:0]  pc, ir, a, b, x, q;
  logic        out_valid;
  logic [15:0] out_stamp;
  logic [7:0]  out_pc, out_ir, out_a, out_b, out_x, out_q;
  logic [3:0]  out_mask;
  logic [4:0]  count;
  logic [7:0]  overflow;

  int n_cmp = 0;
  int n_err = 0;

  trace_fifo #(.WIDTH(8), .DEPTH(16), .STAMP_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pc(pc), .ir(ir), .a(a), .b(b), .x(x), .q(q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_stamp(out_stamp), .out_pc(out_pc), .out_ir(out_ir), .out_mask(out_mask),
    .out_a(out_a), .out_b(out_b), .out_x(out_x), .out_q(out_q),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    pc = 8'h00; ir = 8'h00; a = 8'h00; b = 8'h00; x = 8'h00; q = 8'h00;
    step(); step();
    reset = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
    n_cmp++; if (overflow !== 8'd0) begin n_err++; $display("FAIL rst_overflow got %0d exp 0", overflow); end
    n_cmp++; if (out_stamp !== 16'd0 || out_mask !== 4'd0) begin
      n_err++; $display("FAIL rst_head got stamp=%0h mask=%0b exp 0/0", out_stamp, out_mask); end
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1; pc = 8'h10; ir = 8'h20;
    step();                                   // priming, stamp 0 -> 1
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL prime_count got %0d exp 0", count); end
    a = 8'd5; pc = 8'h11;
    step();                                   // record at stamp 1
    enable = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b exp 1", out_valid); end
    n_cmp++; if (out_mask !== 4'b0001) begin n_err++; $display("FAIL single_mask got %b exp 0001", out_mask); end
    n_cmp++; if (out_a !== 8'd5) begin n_err++; $display("FAIL single_a got %0d exp 5", out_a); end
    n_cmp++; if (out_stamp !== 16'd1) begin n_err++; $display("FAIL single_stamp got %0d exp 1", out_stamp); end
    n_cmp++; if (out_pc !== 8'h11 || out_ir !== 8'h20) begin
      n_err++; $display("FAIL single_pcir got %h/%h exp 11/20", out_pc, out_ir); end
    step(); step();                           // held while not ready
    n_cmp++; if (out_stamp !== 16'd1 || count !== 5'd1) begin
      n_err++; $display("FAIL single_hold got stamp=%0d count=%0d exp 1/1", out_stamp, count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 5'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pop got count=%0d valid=%0b exp 0/0", count, out_valid); end
  endtask

  task automatic test_multi_change();
    // shadows a=5 b=x=q=0, stamp=2 after the disabled gap
    enable = 1'b1;
    b = 8'd3; x = 8'd4;
    step();                                   // record stamp 2, mask 0110
    a = 8'd6; q = 8'd9;
    step();                                   // record stamp 3, mask 1001
    enable = 1'b0;
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL multi_count got %0d exp 2", count); end
    n_cmp++; if (out_mask !== 4'b0110 || out_stamp !== 16'd2) begin
      n_err++; $display("FAIL multi_head1 got mask=%b stamp=%0d exp 0110/2", out_mask, out_stamp); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_mask !== 4'b1001 || out_stamp !== 16'd3) begin
      n_err++; $display("FAIL multi_head2 got mask=%b stamp=%0d exp 1001/3", out_mask, out_stamp); end
    n_cmp++; if (out_a !== 8'd6 || out_b !== 8'd3 || out_x !== 8'd4 || out_q !== 8'd9) begin
      n_err++; $display("FAIL multi_vals got %0d/%0d/%0d/%0d exp 6/3/4/9", out_a, out_b, out_x, out_q); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL multi_drain got %0d exp 0", count); end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [15:0] exp_stamp;
    do_reset();
    enable = 1'b1; a = 8'd0; b = 8'd0; x = 8'd0; q = 8'd0;
    step();                                   // priming, stamp -> 1
    for (int i = 0; i < 20; i++) begin
      a = 8'(i + 1);
      step();                                 // stamps 1..20, 17..20 dropped
    end
    enable = 1'b0;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d exp 16", count); end
    n_cmp++; if (overflow !== 8'd4) begin n_err++; $display("FAIL ovf_overflow got %0d exp 4", overflow); end
    enable = 1'b1; a = 8'd100; out_ready = 1'b1;
    step();                                   // push stamp 21 while popping stamp 1
    enable = 1'b0;
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fullpop_count got %0d exp 16", count); end
    n_cmp++; if (overflow !== 8'd4) begin n_err++; $display("FAIL fullpop_overflow got %0d exp 4", overflow); end
    for (int k = 0; k < 16; k++) begin
      exp_stamp = (k < 15) ? 16'(k + 2) : 16'd21;
      n_cmp++; if (out_valid !== 1'b1 || out_stamp !== exp_stamp) begin
        n_err++; $display("FAIL drain_%0d got valid=%0b stamp=%0d exp 1/%0d", k, out_valid, out_stamp, exp_stamp); end
      if (k == 15) begin
        n_cmp++; if (out_a !== 8'd100) begin n_err++; $display("FAIL tail_a got %0d exp 100", out_a); end
      end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL drain_empty got %0d exp 0", count); end
  endtask

  task automatic test_stamp_wrap();
    do_reset();
    enable = 1'b1; a = 8'd0; b = 8'd0; x = 8'd0; q = 8'd0;
    step();                                   // priming, stamp -> 1
    for (int i = 0; i < 65534; i++) step();   // no changes, stamp -> 16'hFFFF
    a = 8'd1;
    step();                                   // record stamp FFFF
    a = 8'd2;
    step();                                   // record stamp 0000
    enable = 1'b0;
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL wrap_count got %0d exp 2", count); end
    n_cmp++; if (out_stamp !== 16'hFFFF) begin n_err++; $display("FAIL wrap_first got %h exp ffff", out_stamp); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_stamp !== 16'h0000 || out_a !== 8'd2) begin
      n_err++; $display("FAIL wrap_second got stamp=%h a=%0d exp 0000/2", out_stamp, out_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; a = 8'd0; b = 8'd0; x = 8'd0; q = 8'd0;
    step();
    for (int i = 0; i < 7; i++) begin
      b = 8'(i + 10);
      step();
    end
    n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL mid_fill got %0d exp 7", count); end
    reset = 1'b1; out_ready = 1'b1; b = 8'd50;
    step();
    reset = 1'b0; out_ready = 1'b0;
    n_cmp++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 8'd0) begin
      n_err++; $display("FAIL mid_flush got count=%0d valid=%0b ovf=%0d exp 0/0/0", count, out_valid, overflow); end
    b = 8'd60;
    step();                                   // priming only
    n_cmp++; if (count !== 5'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_prime got count=%0d valid=%0b exp 0/0", count, out_valid); end
    b = 8'd61;
    step();
    enable = 1'b0;
    n_cmp++; if (count !== 5'd1 || out_stamp !== 16'd1 || out_mask !== 4'b0010) begin
      n_err++; $display("FAIL mid_first got count=%0d stamp=%0d mask=%b exp 1/1/0010", count, out_stamp, out_mask); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_change();
    test_overflow_and_full_pop();
    test_stamp_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
